bram_scan: RTL and testbench
============================

BRAM_SCAN -- requirements
Module: bram_scan

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the BRAM word width in bits (multiple of 8).
REQ-002 Parameter ADDR_W, default 13, SHALL set the BRAM byte-address width.
REQ-003 Parameter RD_LAT, default 1, SHALL set the BRAM read latency in cycles (1..3).
REQ-004 Parameter RESULT_ADDR, default 0, SHALL set the byte address of the result value; the result index goes at RESULT_ADDR+DATA_W/8.
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 ps_control  in  32  [0] start/ack, [2:1] mode (00 max, 01 min, 10 sum, 11 reserved), [3] signed compare.
REQ-008 ps_base  in  32  [ADDR_W-1:0] start byte address; upper bits ignored.
REQ-009 ps_count  in  32  number of words to scan.
REQ-010 pl_status  out  32  [0] done, [1] error, others 0.
REQ-011 bram_addr  out  ADDR_W  byte address.
REQ-012 bram_rddata  in  DATA_W  read data, valid RD_LAT cycles after its address.
REQ-013 bram_wrdata  out  DATA_W  write data.
REQ-014 bram_we  out  DATA_W/8  byte write enables.

Function
REQ-015 The FSM SHALL have states IDLE, SCAN, DRAIN, WR_VAL, WR_IDX and DONE.
REQ-016 IDLE SHALL drive bram_we=0 and pl_status=0; on ps_control[0]=1 it SHALL latch mode, signed, base and count.
- Valid parameters -> SCAN.
- count==0, base misaligned to DATA_W/8, base+count*DATA_W/8 > 2^ADDR_W, or mode 11 -> DONE with error=1 and no BRAM writes.
REQ-017 SCAN SHALL present one address per cycle, base+i*DATA_W/8 for i=0..count-1; it lasts exactly count cycles, then goes to DRAIN.
REQ-018 A RD_LAT-deep valid pipeline SHALL tag returning data with its word index; DRAIN lasts RD_LAT cycles, then goes to WR_VAL.
REQ-019 The accumulator SHALL load the first valid word unconditionally and then update on each valid word:
- max: replace if the new word is strictly greater (first occurrence wins ties).
- min: replace if strictly less.
- sum: add modulo 2^DATA_W.
- Comparisons are signed when ps_control[3]=1, otherwise unsigned.
REQ-020 For max/min, the tracked index SHALL be the word offset from base of the retained value.
REQ-021 WR_VAL SHALL drive bram_addr=RESULT_ADDR, bram_wrdata=result and bram_we all-ones for one cycle.
REQ-022 WR_IDX SHALL drive bram_addr=RESULT_ADDR+DATA_W/8, bram_wrdata=index (max/min) or count (sum), bram_we all-ones for one cycle, then go to DONE.
REQ-023 DONE SHALL hold pl_status[0]=1 (and [1] if error) until ps_control[0]=0, then return to IDLE.
REQ-024 pl_status[0] SHALL rise exactly count+RD_LAT+3 cycles after the edge that samples start (valid case).
REQ-025 If ps_control[0] falls during SCAN or DRAIN, the block SHALL return to IDLE on the next edge with no BRAM writes (abort).
REQ-026 A result region inside the scanned range is legal; all reads complete before the first write.
REQ-027 bram_we SHALL be zero in every state except WR_VAL and WR_IDX.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, pl_status=0, bram_we=0 and bram_addr=0, and clear the accumulator, index and valid pipeline, including mid-scan; no write occurs after release until a new start.

Structure
REQ-029 Package bram_scan_pkg SHALL hold the state enum, mode encodings and pl_status bit positions.
REQ-030 Compare/accumulate/index tracking SHALL live in sub-module bram_scan_acc; the FSM and address generator go in bram_scan.

Verification
REQ-031 Max, unsigned: base=0x100, count=8, words {3,9,2,9,0,1,7,5} -> mem[0]=9, mem[4]=1, done at cycle 8+RD_LAT+3.
REQ-032 Min, signed, count=4, words {5,-2,0x7FFFFFFF,-2} -> mem[0]=0xFFFFFFFE, mem[4]=1.
REQ-033 Sum, count=3, words {0xFFFFFFFF,2,1} -> mem[0]=2, mem[4]=3.
REQ-034 Error cases: count=0, then base=0x102, then mode=11 -> pl_status=0x3 and no bram_we pulse, each case.
REQ-035 Abort: start=1, count=100, drop start at cycle 20 -> IDLE next edge and no writes; reset_n pulsed mid-scan -> outputs zero asynchronously.
REQ-036 Parameter sweep RD_LAT=1,2,3 with DATA_W=16/ADDR_W=10 -> results and done latency per REQ-024.

Source files
------------

// File: rtl/bram_scan_pkg.sv
// Shared types and encodings for the BRAM scan/reduce engine.
package bram_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_WR_VAL,
    ST_WR_IDX,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_MAX  = 2'b00,
    MODE_MIN  = 2'b01,
    MODE_SUM  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  localparam int CTRL_START    = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_SIGNED   = 3;

  localparam int STAT_DONE = 0;
  localparam int STAT_ERR  = 1;

endpackage

// File: rtl/bram_scan_acc.sv
// Running max/min/sum over tagged words; exposes the next value so a write can capture it on the final update edge.
module bram_scan_acc
  import bram_scan_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 13
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  logic [TAG_W-1:0]  tag,
  input  mode_t             mode,
  input  logic              sgn,
  output logic [DATA_W-1:0] res_nxt,
  output logic [DATA_W-1:0] idx_nxt
);

  logic [DATA_W-1:0] res;
  logic [DATA_W-1:0] idx_q;
  logic              have;
  logic              gt;
  logic              lt;

  always_comb begin
    if (sgn) begin
      gt = $signed(data) > $signed(res);
      lt = $signed(data) < $signed(res);
    end else begin
      gt = data > res;
      lt = data < res;
    end
  end

  // Strict compares keep the earliest index on ties.
  always_comb begin
    res_nxt = res;
    idx_nxt = idx_q;
    if (valid) begin
      case (mode)
        MODE_SUM: res_nxt = have ? res + data : data;
        MODE_MIN: begin
          if (!have || lt) begin
            res_nxt = data;
            idx_nxt = DATA_W'(tag);
          end
        end
        default: begin
          if (!have || gt) begin
            res_nxt = data;
            idx_nxt = DATA_W'(tag);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res   <= '0;
      idx_q <= '0;
      have  <= 1'b0;
    end else if (clear) begin
      res   <= '0;
      idx_q <= '0;
      have  <= 1'b0;
    end else if (valid) begin
      res   <= res_nxt;
      idx_q <= idx_nxt;
      have  <= 1'b1;
    end
  end

endmodule

// File: rtl/bram_scan.sv
// Scans a block of BRAM words, reduces them (max/min/sum) and writes value and index back to a fixed result location.
//  state    | meaning
//  IDLE     | outputs quiet, waiting for start; checks parameters
//  SCAN     | one read address per cycle, count cycles
//  DRAIN    | waits RD_LAT cycles for in-flight read data
//  WR_VAL   | writes reduced value to RESULT_ADDR
//  WR_IDX   | writes index (max/min) or count (sum) to RESULT_ADDR+bytes
//  DONE     | status held until start is released
module bram_scan
  import bram_scan_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 13,
  parameter int RD_LAT      = 1,
  parameter int RESULT_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           ps_control,
  input  logic [31:0]           ps_base,
  input  logic [31:0]           ps_count,
  output logic [31:0]           pl_status,
  output logic [ADDR_W-1:0]     bram_addr,
  input  logic [DATA_W-1:0]     bram_rddata,
  output logic [DATA_W-1:0]     bram_wrdata,
  output logic [DATA_W/8-1:0]   bram_we
);

  localparam int              BYTES      = DATA_W / 8;
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(BYTES);
  localparam logic [ADDR_W-1:0] RES_A    = ADDR_W'(RESULT_ADDR);
  localparam logic [ADDR_W-1:0] RES_I    = ADDR_W'(RESULT_ADDR + BYTES);
  localparam logic [1:0]      DRAIN_INIT = 2'(RD_LAT - 1);

  state_t            state;
  mode_t             mode;
  logic              sgn;
  logic [31:0]       count;
  logic [31:0]       left;
  logic [1:0]        drain_left;
  logic [ADDR_W-1:0] idx_cnt;
  logic              err;

  logic [RD_LAT-1:0] vld;
  logic [ADDR_W-1:0] tag_pipe [RD_LAT];

  logic              start;
  logic [ADDR_W-1:0] base_a;
  logic [63:0]       end_b;
  logic              bad;
  logic [DATA_W-1:0] res_nxt;
  logic [DATA_W-1:0] idx_nxt;
  logic              unused_bits;

  assign start       = ps_control[CTRL_START];
  assign base_a      = ps_base[ADDR_W-1:0];
  assign end_b       = 64'(base_a) + 64'(ps_count) * 64'(BYTES);
  assign unused_bits = ^{ps_control[31:4], ps_base[31:ADDR_W]};

  always_comb begin
    bad = (ps_count == 32'd0) ||
          ((base_a % STEP) != '0) ||
          (end_b > (64'd1 << ADDR_W)) ||
          (mode_t'(ps_control[CTRL_MODE_LSB +: 2]) == MODE_RSVD);
  end

  // Valid/index pipeline lines up with read data RD_LAT cycles after each address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
      for (int k = 0; k < RD_LAT; k++) tag_pipe[k] <= '0;
    end else if (state == ST_IDLE) begin
      vld <= '0;
    end else begin
      vld[0]      <= (state == ST_SCAN);
      tag_pipe[0] <= idx_cnt;
      for (int k = 1; k < RD_LAT; k++) begin
        vld[k]      <= vld[k-1];
        tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

  bram_scan_acc #(
    .DATA_W (DATA_W),
    .TAG_W  (ADDR_W)
  ) u_acc (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state == ST_IDLE),
    .valid   (vld[RD_LAT-1]),
    .data    (bram_rddata),
    .tag     (tag_pipe[RD_LAT-1]),
    .mode    (mode),
    .sgn     (sgn),
    .res_nxt (res_nxt),
    .idx_nxt (idx_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      mode        <= MODE_MAX;
      sgn         <= 1'b0;
      count       <= '0;
      left        <= '0;
      drain_left  <= '0;
      idx_cnt     <= '0;
      err         <= 1'b0;
      pl_status   <= '0;
      bram_addr   <= '0;
      bram_wrdata <= '0;
      bram_we     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bram_we   <= '0;
          pl_status <= '0;
          if (start) begin
            mode      <= mode_t'(ps_control[CTRL_MODE_LSB +: 2]);
            sgn       <= ps_control[CTRL_SIGNED];
            count     <= ps_count;
            left      <= ps_count - 32'd1;
            idx_cnt   <= '0;
            bram_addr <= base_a;
            err       <= bad;
            state     <= bad ? ST_DONE : ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!start) begin
            state <= ST_IDLE;
          end else if (left == 32'd0) begin
            drain_left <= DRAIN_INIT;
            state      <= ST_DRAIN;
          end else begin
            left      <= left - 32'd1;
            bram_addr <= bram_addr + STEP;
            idx_cnt   <= idx_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!start) begin
            state <= ST_IDLE;
          end else if (drain_left == 2'd0) begin
            // The last word is being absorbed on this edge, so take the accumulator's next value.
            bram_addr   <= RES_A;
            bram_wrdata <= res_nxt;
            bram_we     <= '1;
            state       <= ST_WR_VAL;
          end else begin
            drain_left <= drain_left - 2'd1;
          end
        end
        ST_WR_VAL: begin
          bram_addr   <= RES_I;
          bram_wrdata <= (mode == MODE_SUM) ? DATA_W'(count) : idx_nxt;
          bram_we     <= '1;
          state       <= ST_WR_IDX;
        end
        ST_WR_IDX: begin
          bram_we <= '0;
          state   <= ST_DONE;
        end
        ST_DONE: begin
          bram_we <= '0;
          if (!start) begin
            pl_status <= '0;
            state     <= ST_IDLE;
          end else begin
            pl_status            <= '0;
            pl_status[STAT_DONE] <= 1'b1;
            pl_status[STAT_ERR]  <= err;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_scan.sv
// Self-checking bench: vector table on a 32-bit instance plus an RD_LAT sweep on three 16-bit instances.
module tb_bram_scan;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] ps_control = '0;
  logic [31:0] ps_base = '0;
  logic [31:0] ps_count = '0;
  logic [31:0] pl_status;
  logic [12:0] bram_addr;
  logic [31:0] bram_rddata;
  logic [31:0] bram_wrdata;
  logic [3:0]  bram_we;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_scan #(.DATA_W(32), .ADDR_W(13), .RD_LAT(1), .RESULT_ADDR(0)) dut (
    .clk(clk), .reset_n(reset_n), .ps_control(ps_control), .ps_base(ps_base),
    .ps_count(ps_count), .pl_status(pl_status), .bram_addr(bram_addr),
    .bram_rddata(bram_rddata), .bram_wrdata(bram_wrdata), .bram_we(bram_we)
  );

  logic [31:0] mem_main [2048];
  logic [31:0] rd_q;
  always @(posedge clk) rd_q <= mem_main[bram_addr[12:2]];
  assign bram_rddata = rd_q;

  int          wr_n = 0;
  logic [12:0] wr_addr_log [64];
  logic [31:0] wr_data_log [64];
  logic [3:0]  wr_we_log   [64];
  always @(negedge clk) begin
    if (bram_we != 4'd0) begin
      if (wr_n < 64) begin
        wr_addr_log[wr_n] <= bram_addr;
        wr_data_log[wr_n] <= bram_wrdata;
        wr_we_log[wr_n]   <= bram_we;
      end
      wr_n <= wr_n + 1;
    end
  end

  // RD_LAT sweep instances share one stimulus and one read image
  logic [15:0] sw_mem [512];
  logic [31:0] sw_control = '0;
  logic [31:0] sw_base = '0;
  logic [31:0] sw_count = '0;
  logic [15:0] sw_val  [3];
  logic [15:0] sw_idx  [3];
  int          sw_wn   [3];
  int          sw_done [3];
  logic        sw_seen [3];
  logic [31:0] sw_stat [3];

  for (genvar k = 0; k < 3; k++) begin : g_sw
    localparam int L = k + 1;
    logic [9:0]  addr;
    logic [15:0] pipe [L];
    logic [15:0] wd;
    logic [1:0]  we;
    logic [31:0] stat;
    logic [15:0] val = 16'h5A5A;
    logic [15:0] idx = 16'h5A5A;
    int          wn = 0;
    int          dc = 0;
    logic        seen = 1'b0;

    bram_scan #(.DATA_W(16), .ADDR_W(10), .RD_LAT(L), .RESULT_ADDR(0)) dut (
      .clk(clk), .reset_n(reset_n), .ps_control(sw_control), .ps_base(sw_base),
      .ps_count(sw_count), .pl_status(stat), .bram_addr(addr),
      .bram_rddata(pipe[L-1]), .bram_wrdata(wd), .bram_we(we)
    );

    always @(posedge clk) begin
      pipe[0] <= sw_mem[addr[9:1]];
      for (int j = 1; j < L; j++) pipe[j] <= pipe[j-1];
    end

    always @(negedge clk) begin
      if (!sw_control[0]) begin
        wn   <= 0;
        seen <= 1'b0;
        val  <= 16'h5A5A;
        idx  <= 16'h5A5A;
      end else begin
        if (we != 2'd0) begin
          wn <= wn + 1;
          if (addr == 10'd0 && we == 2'b11) val <= wd;
          else if (addr == 10'd2 && we == 2'b11) idx <= wd;
        end
        if (stat[0] && !seen) begin
          seen <= 1'b1;
          dc   <= cyc;
        end
      end
    end

    assign sw_val[k]  = val;
    assign sw_idx[k]  = idx;
    assign sw_wn[k]   = wn;
    assign sw_done[k] = dc;
    assign sw_seen[k] = seen;
    assign sw_stat[k] = stat;
  end

  typedef struct packed {
    logic [1:0]        mode;
    logic              sgn;
    logic [31:0]       base;
    logic [31:0]       count;
    logic [0:7][31:0]  words;
    logic              err;
    logic [31:0]       val;
    logic [31:0]       idx;
  } vec_t;

  typedef struct packed {
    logic [1:0]       mode;
    logic             sgn;
    logic [31:0]      base;
    logic [31:0]      count;
    logic [0:5][15:0] words;
    logic [15:0]      val;
    logic [15:0]      idx;
  } sw_vec_t;

  typedef struct packed {
    logic [12:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q [$];
  vec_t vecs [10];
  sw_vec_t sw_vecs [3];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int  w0;
    int  lat;
    wr_t e;
    if (!v.err) begin
      for (int j = 0; j < 8 && j < int'(v.count); j++) mem_main[int'(v.base >> 2) + j] = v.words[j];
      exp_q.push_back('{addr: 13'd0, data: v.val});
      exp_q.push_back('{addr: 13'd4, data: v.idx});
    end
    w0 = wr_n;
    @(negedge clk);
    ps_base    = v.base;
    ps_count   = v.count;
    ps_control = {28'd0, v.sgn, v.mode, 1'b1};
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      if (pl_status[0]) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within 300 cycles, expected done");
    end
    if (!v.err) chk("done_latency", 64'(lat), 64'(v.count) + 64'd4);
    chk("status", 64'(pl_status), v.err ? 64'h3 : 64'h1);
    @(negedge clk);
    chk("write_count", 64'(wr_n - w0), v.err ? 64'd0 : 64'd2);
    for (int i = w0; i < wr_n && i < 64; i++) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_write: got addr %0h data %0h expected no write", wr_addr_log[i], wr_data_log[i]);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 64'(wr_addr_log[i]), 64'(e.addr));
        chk("write_data", 64'(wr_data_log[i]), 64'(e.data));
        chk("write_we", 64'(wr_we_log[i]), 64'hF);
      end
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_write: got none expected addr %0h data %0h", e.addr, e.data);
    end
    ps_control = '0;
    @(posedge clk);
    #1;
    chk("status_release", 64'(pl_status), 64'h0);
  endtask

  task automatic run_sweep(input sw_vec_t v);
    int  t0;
    bit  all;
    for (int j = 0; j < 6; j++) sw_mem[int'(v.base >> 1) + j] = v.words[j];
    @(negedge clk);
    sw_base    = v.base;
    sw_count   = v.count;
    sw_control = {28'd0, v.sgn, v.mode, 1'b1};
    @(posedge clk);
    #1;
    t0  = cyc;
    all = 1'b0;
    for (int k = 0; k < 100 && !all; k++) begin
      @(posedge clk);
      #1;
      all = sw_seen[0] && sw_seen[1] && sw_seen[2];
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!sw_seen[k]) begin
        checks++;
        errors++;
        $display("FAIL sweep_timeout: lat%0d got no done expected done", k + 1);
      end else begin
        chk("sweep_latency", 64'(sw_done[k] - t0), 64'(v.count) + 64'(k + 1) + 64'd3);
      end
      chk("sweep_status", 64'(sw_stat[k]), 64'h1);
      chk("sweep_val", 64'(sw_val[k]), 64'(v.val));
      chk("sweep_idx", 64'(sw_idx[k]), 64'(v.idx));
      chk("sweep_writes", 64'(sw_wn[k]), 64'd2);
    end
    sw_control = '0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int w0;
    vecs[0] = '{2'd0, 1'b0, 32'h100, 32'd8, {32'd3, 32'd9, 32'd2, 32'd9, 32'd0, 32'd1, 32'd7, 32'd5}, 1'b0, 32'd9, 32'd1};
    vecs[1] = '{2'd1, 1'b1, 32'h200, 32'd4, {32'd5, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'hFFFFFFFE, 128'd0}, 1'b0, 32'hFFFFFFFE, 32'd1};
    vecs[2] = '{2'd2, 1'b0, 32'h040, 32'd3, {32'hFFFFFFFF, 32'd2, 32'd1, 160'd0}, 1'b0, 32'd2, 32'd3};
    vecs[3] = '{2'd0, 1'b1, 32'h000, 32'd5, {32'd1, 32'hFFFFFFFB, 32'h80000000, 32'd7, 32'd7, 96'd0}, 1'b0, 32'd7, 32'd3};
    vecs[4] = '{2'd1, 1'b0, 32'h300, 32'd4, {32'd10, 32'hFFFFFFFF, 32'd3, 32'd3, 128'd0}, 1'b0, 32'd3, 32'd2};
    vecs[5] = '{2'd0, 1'b0, 32'h1FF8, 32'd2, {32'd4, 32'hFFFFFFF0, 192'd0}, 1'b0, 32'hFFFFFFF0, 32'd1};
    vecs[6] = '{2'd0, 1'b0, 32'h100, 32'd0, 256'd0, 1'b1, 32'd0, 32'd0};
    vecs[7] = '{2'd0, 1'b0, 32'h102, 32'd4, 256'd0, 1'b1, 32'd0, 32'd0};
    vecs[8] = '{2'd3, 1'b0, 32'h100, 32'd4, 256'd0, 1'b1, 32'd0, 32'd0};
    vecs[9] = '{2'd0, 1'b0, 32'h1FF8, 32'd3, 256'd0, 1'b1, 32'd0, 32'd0};

    sw_vecs[0] = '{2'd0, 1'b0, 32'h010, 32'd6, {16'h0010, 16'h8000, 16'h7FFF, 16'h8000, 16'h0001, 16'h0002}, 16'h8000, 16'd1};
    sw_vecs[1] = '{2'd0, 1'b1, 32'h010, 32'd6, {16'h0010, 16'h8000, 16'h7FFF, 16'h8000, 16'h0001, 16'h0002}, 16'h7FFF, 16'd2};
    sw_vecs[2] = '{2'd2, 1'b0, 32'h3F0, 32'd6, {16'h0010, 16'h8000, 16'h7FFF, 16'h8000, 16'h0001, 16'h0002}, 16'h8012, 16'd6};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_status", 64'(pl_status), 64'h0);
    chk("reset_we", 64'(bram_we), 64'h0);
    chk("reset_addr", 64'(bram_addr), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Abort mid-scan: drop start while addresses are still being issued
    w0 = wr_n;
    @(negedge clk);
    ps_base    = 32'h0;
    ps_count   = 32'd100;
    ps_control = 32'h1;
    @(posedge clk);
    repeat (19) @(posedge clk);
    @(negedge clk);
    ps_control = 32'h0;
    @(posedge clk);
    #1;
    chk("abort_status", 64'(pl_status), 64'h0);
    chk("abort_we", 64'(bram_we), 64'h0);
    repeat (150) @(posedge clk);
    #1;
    chk("abort_no_write", 64'(wr_n - w0), 64'd0);
    chk("abort_status_late", 64'(pl_status), 64'h0);
    run_vec(vecs[0]);

    // Asynchronous reset in the middle of a scan
    w0 = wr_n;
    @(negedge clk);
    ps_base    = 32'h100;
    ps_count   = 32'd100;
    ps_control = 32'h1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #2;
    chk("scan_addr", 64'(bram_addr), 64'h128);
    reset_n = 1'b0;
    #1;
    chk("async_reset_addr", 64'(bram_addr), 64'h0);
    chk("async_reset_we", 64'(bram_we), 64'h0);
    chk("async_reset_status", 64'(pl_status), 64'h0);
    ps_control = 32'h0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (150) @(posedge clk);
    #1;
    chk("reset_no_write", 64'(wr_n - w0), 64'd0);
    run_vec(vecs[1]);

    for (int i = 0; i < 3; i++) run_sweep(sw_vecs[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
